apb_bridge_controller: RTL and testbench

Sequences the AHB-to-APB bridge. It accepts one AHB transfer at a time, drives APB SETUP/ACCESS phases onto the APB interface signals (Pselx, Paddr, Pwrite, Pwdata, Penable), and stalls the AHB side with Hreadyout until the APB slave completes. It also generates AHB error responses for unmapped selects, Pslverr, and APB wait-state timeout. It sits between the AHB slave front end (address/select decode) and the APB interface block.

---
 rtl/apb_bridge_controller.sv | 136 +++++++++++++
 tb/tb_apb_bridge_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_controller.sv
// AHB-to-APB bridge sequencer: one AHB transfer at a time is turned into an
// APB SETUP/ACCESS pair, with AHB stalls and two-cycle ERROR responses.
module apb_bridge_controller #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NSEL       = 3,
   parameter int MAX_WAIT   = 16
) (
   input  logic                  Hclk,
   input  logic                  Hresetn,
   input  logic                  valid,
   input  logic [ADDR_WIDTH-1:0] Haddr,
   input  logic                  Hwrite,
   input  logic [NSEL-1:0]       tempselx,
   input  logic [DATA_WIDTH-1:0] Hwdata,
   input  logic                  Pready,
   input  logic                  Pslverr,
   input  logic [DATA_WIDTH-1:0] Prdata,
   output logic [NSEL-1:0]       Pselx,
   output logic                  Penable,
   output logic                  Pwrite,
   output logic [ADDR_WIDTH-1:0] Paddr,
   output logic [DATA_WIDTH-1:0] Pwdata,
   output logic                  Hreadyout,
   output logic                  Hresp,
   output logic [DATA_WIDTH-1:0] Hrdata
);

   localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [CW-1:0] WAIT_MAX  = CW'(MAX_WAIT);
   localparam logic [CW-1:0] WAIT_LAST = (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : '0;

   typedef enum logic [2:0] {
      IDLE,
      WWAIT,
      SETUP,
      ACCESS,
      ERR1,
      ERR2
   } state_t;

   state_t          state_q;
   state_t          state_d;
   state_t          accept_state;
   logic [NSEL-1:0] sel_q;
   logic [NSEL-1:0] sel_nxt;
   logic [CW-1:0]   wait_cnt;
   logic            sel_ok;
   logic            accept;
   logic            take;
   logic            timeout;

   always_comb begin
      sel_ok       = $onehot(tempselx);
      accept_state = !sel_ok ? ERR1 : (Hwrite ? WWAIT : SETUP);
      timeout      = (MAX_WAIT > 0) && (wait_cnt >= WAIT_LAST);
      state_d      = state_q;
      accept       = 1'b0;
      Hreadyout    = 1'b0;
      Hresp        = 1'b0;
      Hrdata       = '0;

      case (state_q)
         IDLE: begin
            Hreadyout = 1'b1;
            state_d   = IDLE;
            if (valid) begin
               accept  = 1'b1;
               state_d = accept_state;
            end
         end
         WWAIT: state_d = SETUP;
         SETUP: state_d = ACCESS;
         ACCESS: begin
            if (Pready) begin
               if (Pslverr) begin
                  state_d = ERR1;
               end else begin
                  // Completing cycle doubles as the next address phase.
                  Hreadyout = 1'b1;
                  Hrdata    = Pwrite ? '0 : Prdata;
                  state_d   = IDLE;
                  if (valid) begin
                     accept  = 1'b1;
                     state_d = accept_state;
                  end
               end
            end else if (timeout) begin
               state_d = ERR1;
            end
         end
         ERR1: begin
            Hresp   = 1'b1;
            state_d = ERR2;
         end
         ERR2: begin
            Hreadyout = 1'b1;
            Hresp     = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      take    = accept && sel_ok;
      sel_nxt = take ? tempselx : sel_q;
   end

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         Pselx    <= '0;
         Penable  <= 1'b0;
         Pwrite   <= 1'b0;
         Paddr    <= '0;
         Pwdata   <= '0;
         wait_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (take) begin
            sel_q  <= tempselx;
            Paddr  <= Haddr;
            Pwrite <= Hwrite;
         end
         if (state_q == WWAIT) Pwdata <= Hwdata;
         Pselx   <= (state_d == SETUP || state_d == ACCESS) ? sel_nxt : '0;
         Penable <= (state_d == ACCESS);
         if (state_d == SETUP) begin
            wait_cnt <= '0;
         end else if (state_q == ACCESS && !Pready && wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_apb_bridge_controller.sv
// Bench for apb_bridge_controller: directed vector table, async reset check,
// then random transfers compared against a transaction-level model.
module tb_apb_bridge_controller;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 3;
   localparam int MW = 4;

   logic          Hclk = 1'b0;
   logic          Hresetn;
   logic          valid;
   logic [AW-1:0] Haddr;
   logic          Hwrite;
   logic [NS-1:0] tempselx;
   logic [DW-1:0] Hwdata;
   logic          Pready;
   logic          Pslverr;
   logic [DW-1:0] Prdata;
   logic [NS-1:0] Pselx;
   logic          Penable;
   logic          Pwrite;
   logic [AW-1:0] Paddr;
   logic [DW-1:0] Pwdata;
   logic          Hreadyout;
   logic          Hresp;
   logic [DW-1:0] Hrdata;

   apb_bridge_controller #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .NSEL(NS),
      .MAX_WAIT(MW)
   ) dut (
      .Hclk(Hclk), .Hresetn(Hresetn), .valid(valid), .Haddr(Haddr), .Hwrite(Hwrite),
      .tempselx(tempselx), .Hwdata(Hwdata), .Pready(Pready), .Pslverr(Pslverr),
      .Prdata(Prdata), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
      .Pwdata(Pwdata), .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata)
   );

   always #5 Hclk = ~Hclk;

   typedef struct {
      string         name;
      logic          valid;
      logic [AW-1:0] haddr;
      logic          hwrite;
      logic [NS-1:0] sel;
      logic [DW-1:0] hwdata;
      logic          pready;
      logic          pslverr;
      logic [DW-1:0] prdata;
      logic          e_rdy;
      logic          e_resp;
      logic [NS-1:0] e_psel;
      logic          e_pen;
      logic          chk;
      logic          e_pwrite;
      logic [AW-1:0] e_paddr;
      logic [DW-1:0] e_pwdata;
      logic [DW-1:0] e_hrdata;
   } vec_t;

   vec_t        tbl[$];
   vec_t        q[$];
   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] m_pwdata;

   function automatic vec_t mk(input string nm,
                               input logic [31:0] vl, ad, wr, sl, wd, rdy_in, err_in, rd,
                               input logic [31:0] rdy, resp, psel, pen, chk, pwr, pad, pwd, hrd);
      vec_t v;
      v.name = nm;       v.valid = vl[0];    v.haddr = ad;        v.hwrite = wr[0];
      v.sel = sl[NS-1:0]; v.hwdata = wd;     v.pready = rdy_in[0]; v.pslverr = err_in[0];
      v.prdata = rd;     v.e_rdy = rdy[0];   v.e_resp = resp[0];  v.e_psel = psel[NS-1:0];
      v.e_pen = pen[0];  v.chk = chk[0];     v.e_pwrite = pwr[0]; v.e_paddr = pad;
      v.e_pwdata = pwd;  v.e_hrdata = hrd;
      return v;
   endfunction

   function automatic logic [31:0] rb();
      return $urandom & 32'd1;
   endfunction

   task automatic check(input vec_t v);
      logic bad;
      bad = (Hreadyout !== v.e_rdy) || (Hresp !== v.e_resp) || (Pselx !== v.e_psel) ||
            (Penable !== v.e_pen) || (Hrdata !== v.e_hrdata);
      if (v.chk)
         bad = bad || (Pwrite !== v.e_pwrite) || (Paddr !== v.e_paddr) || (Pwdata !== v.e_pwdata);
      n_vec++;
      if (bad) begin
         n_bad++;
         $display("FAIL %s @%0t: got rdy=%b resp=%b psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h hrdata=%h; want rdy=%b resp=%b psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h hrdata=%h (apb fields checked=%b)",
                  v.name, $time, Hreadyout, Hresp, Pselx, Penable, Pwrite, Paddr, Pwdata, Hrdata,
                  v.e_rdy, v.e_resp, v.e_psel, v.e_pen, v.e_pwrite, v.e_paddr, v.e_pwdata, v.e_hrdata, v.chk);
      end
   endtask

   task automatic apply(input vec_t v);
      @(posedge Hclk);
      #1;
      valid = v.valid;  Haddr = v.haddr;    Hwrite = v.hwrite; tempselx = v.sel;
      Hwdata = v.hwdata; Pready = v.pready; Pslverr = v.pslverr; Prdata = v.prdata;
      @(negedge Hclk);
      check(v);
   endtask

   task automatic run_q();
      while (q.size() > 0) apply(q.pop_front());
   endtask

   // Transaction-level model: expands one AHB transfer into its expected cycle trace.
   task automatic model_txn(input logic [31:0] sel, wr, addr, wdata, rdata, input int w, input logic [31:0] serr);
      q.push_back(mk("rnd_addr", 1, addr, wr, sel, $urandom, rb(), rb(), $urandom, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      if (!$onehot(sel[NS-1:0])) begin
         q.push_back(mk("rnd_err1", 0, $urandom, rb(), $urandom, $urandom, rb(), rb(), $urandom, 0, 1, 0, 0, 0, 0, 0, 0, 0));
         q.push_back(mk("rnd_err2", 1, $urandom, rb(), 'b001, $urandom, rb(), rb(), $urandom, 1, 1, 0, 0, 0, 0, 0, 0, 0));
         return;
      end
      if (wr[0]) begin
         q.push_back(mk("rnd_wwait", 0, $urandom, rb(), $urandom, wdata, rb(), rb(), $urandom, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         m_pwdata = wdata;
      end
      q.push_back(mk("rnd_setup", 0, $urandom, rb(), $urandom, $urandom, rb(), rb(), $urandom, 0, 0, sel, 0, 1, wr, addr, m_pwdata, 0));
      for (int i = 0; i < ((w >= MW) ? MW : w); i++)
         q.push_back(mk("rnd_wait", 0, $urandom, rb(), $urandom, $urandom, 0, rb(), $urandom, 0, 0, sel, 1, 1, wr, addr, m_pwdata, 0));
      if (w < MW && serr == 0) begin
         q.push_back(mk("rnd_done", 0, $urandom, rb(), $urandom, $urandom, 1, 0, rdata, 1, 0, sel, 1, 1, wr, addr, m_pwdata,
                        wr[0] ? 32'd0 : rdata));
         return;
      end
      if (w < MW)
         q.push_back(mk("rnd_slverr", 0, $urandom, rb(), $urandom, $urandom, 1, 1, rdata, 0, 0, sel, 1, 1, wr, addr, m_pwdata, 0));
      q.push_back(mk("rnd_err1", 0, $urandom, rb(), $urandom, $urandom, rb(), rb(), $urandom, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      q.push_back(mk("rnd_err2", 1, $urandom, rb(), 'b001, $urandom, rb(), rb(), $urandom, 1, 1, 0, 0, 0, 0, 0, 0, 0));
   endtask

   initial begin
      Hresetn = 1'b0; valid = 1'b0; Haddr = '0; Hwrite = 1'b0; tempselx = '0;
      Hwdata = '0; Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;

      // write, 0 waits
      tbl.push_back(mk("wr0_addr",   1, 'h8000_0010, 1, 'b001, 0, 0, 0, 0,          1, 0, 0, 0,     0, 0, 0, 0, 0));
      tbl.push_back(mk("wr0_wwait",  0, 0, 0, 0, 'hDEAD_BEEF, 0, 0, 0,             0, 0, 0, 0,     0, 0, 0, 0, 0));
      tbl.push_back(mk("wr0_setup",  0, 0, 0, 0, 0, 0, 0, 0,                       0, 0, 'b001, 0, 1, 1, 'h8000_0010, 'hDEAD_BEEF, 0));
      tbl.push_back(mk("wr0_access", 0, 0, 0, 0, 0, 1, 0, 'h1234,                  1, 0, 'b001, 1, 1, 1, 'h8000_0010, 'hDEAD_BEEF, 0));
      // read, 2 waits
      tbl.push_back(mk("rd2_addr",   1, 'h8400_0004, 0, 'b010, 0, 0, 0, 0,          1, 0, 0, 0,     0, 0, 0, 0, 0));
      tbl.push_back(mk("rd2_setup",  0, 0, 0, 0, 0, 0, 0, 0,                       0, 0, 'b010, 0, 1, 0, 'h8400_0004, 'hDEAD_BEEF, 0));
      tbl.push_back(mk("rd2_wait1",  0, 0, 0, 0, 0, 0, 0, 'h1E,                    0, 0, 'b010, 1, 1, 0, 'h8400_0004, 'hDEAD_BEEF, 0));
      tbl.push_back(mk("rd2_wait2",  0, 0, 0, 0, 0, 0, 1, 'h1E,                    0, 0, 'b010, 1, 1, 0, 'h8400_0004, 'hDEAD_BEEF, 0));
      tbl.push_back(mk("rd2_done",   0, 0, 0, 0, 0, 1, 0, 'h1E,                    1, 0, 'b010, 1, 1, 0, 'h8400_0004, 'hDEAD_BEEF, 'h1E));
      tbl.push_back(mk("rd2_idle",   0, 0, 0, 0, 0, 1, 0, 'h1E,                    1, 0, 0, 0,     0, 0, 0, 0, 0));
      // back-to-back write then read
      tbl.push_back(mk("b2b_addr",   1, 'h1000_0000, 1, 'b100, 0, 0, 0, 0,          1, 0, 0, 0,     0, 0, 0, 0, 0));
      tbl.push_back(mk("b2b_wwait",  0, 0, 0, 0, 'h1111_1111, 0, 0, 0,             0, 0, 0, 0,     0, 0, 0, 0, 0));
      tbl.push_back(mk("b2b_wsetup", 0, 0, 0, 0, 0, 0, 0, 0,                       0, 0, 'b100, 0, 1, 1, 'h1000_0000, 'h1111_1111, 0));
      tbl.push_back(mk("b2b_wdone",  1, 'h2000_0008, 0, 'b001, 0, 1, 0, 'h77,       1, 0, 'b100, 1, 1, 1, 'h1000_0000, 'h1111_1111, 0));
      tbl.push_back(mk("b2b_rsetup", 0, 0, 0, 0, 0, 0, 0, 0,                       0, 0, 'b001, 0, 1, 0, 'h2000_0008, 'h1111_1111, 0));
      tbl.push_back(mk("b2b_rdone",  0, 0, 0, 0, 0, 1, 0, 'h55,                    1, 0, 'b001, 1, 1, 0, 'h2000_0008, 'h1111_1111, 'h55));
      tbl.push_back(mk("b2b_idle",   0, 0, 0, 0, 0, 0, 0, 0,                       1, 0, 0, 0,     0, 0, 0, 0, 0));
      // unmapped select
      tbl.push_back(mk("nosel_addr", 1, 'h7000, 1, 'b000, 0, 0, 0, 0,               1, 0, 0, 0,     0, 0, 0, 0, 0));
      tbl.push_back(mk("nosel_err1", 0, 0, 0, 0, 0, 1, 0, 0,                       0, 1, 0, 0,     0, 0, 0, 0, 0));
      tbl.push_back(mk("nosel_err2", 1, 'h7004, 0, 'b010, 0, 1, 0, 0,               1, 1, 0, 0,     0, 0, 0, 0, 0));
      tbl.push_back(mk("nosel_idle", 0, 0, 0, 0, 0, 0, 0, 0,                       1, 0, 0, 0,     0, 0, 0, 0, 0));
      // slave error
      tbl.push_back(mk("serr_addr",  1, 'h30, 0, 'b010, 0, 0, 0, 0,                 1, 0, 0, 0,     0, 0, 0, 0, 0));
      tbl.push_back(mk("serr_setup", 0, 0, 0, 0, 0, 0, 0, 0,                       0, 0, 'b010, 0, 1, 0, 'h30, 'h1111_1111, 0));
      tbl.push_back(mk("serr_acc",   0, 0, 0, 0, 0, 1, 1, 'hAA,                    0, 0, 'b010, 1, 1, 0, 'h30, 'h1111_1111, 0));
      tbl.push_back(mk("serr_err1",  0, 0, 0, 0, 0, 0, 0, 0,                       0, 1, 0, 0,     0, 0, 0, 0, 0));
      tbl.push_back(mk("serr_err2",  0, 0, 0, 0, 0, 0, 0, 0,                       1, 1, 0, 0,     0, 0, 0, 0, 0));
      tbl.push_back(mk("serr_idle",  0, 0, 0, 0, 0, 0, 0, 0,                       1, 0, 0, 0,     0, 0, 0, 0, 0));
      // wait-state timeout after MW ACCESS cycles
      tbl.push_back(mk("tmo_addr",   1, 'h40, 1, 'b001, 0, 0, 0, 0,                 1, 0, 0, 0,     0, 0, 0, 0, 0));
      tbl.push_back(mk("tmo_wwait",  0, 0, 0, 0, 'hCAFE_F00D, 0, 0, 0,             0, 0, 0, 0,     0, 0, 0, 0, 0));
      tbl.push_back(mk("tmo_setup",  0, 0, 0, 0, 0, 0, 0, 0,                       0, 0, 'b001, 0, 1, 1, 'h40, 'hCAFE_F00D, 0));
      for (int i = 0; i < MW; i++)
         tbl.push_back(mk("tmo_wait", 0, 0, 0, 0, 0, 0, 0, 0,                      0, 0, 'b001, 1, 1, 1, 'h40, 'hCAFE_F00D, 0));
      tbl.push_back(mk("tmo_err1",   0, 0, 0, 0, 0, 1, 0, 0,                       0, 1, 0, 0,     0, 0, 0, 0, 0));
      tbl.push_back(mk("tmo_err2",   0, 0, 0, 0, 0, 1, 0, 0,                       1, 1, 0, 0,     0, 0, 0, 0, 0));
      tbl.push_back(mk("tmo_idle",   0, 0, 0, 0, 0, 0, 0, 0,                       1, 0, 0, 0,     0, 0, 0, 0, 0));

      #12;
      check(mk("reset_state", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
      @(negedge Hclk);
      Hresetn = 1'b1;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // asynchronous reset in the middle of a stalled ACCESS
      apply(mk("rst_addr",  1, 'h50, 0, 'b100, 0, 0, 0, 0, 1, 0, 0, 0,     0, 0, 0, 0, 0));
      apply(mk("rst_setup", 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 'b100, 0, 0, 0, 0, 0, 0));
      apply(mk("rst_acc",   0, 0, 0, 0, 0, 0, 0, 'h99,     0, 0, 'b100, 1, 0, 0, 0, 0, 0));
      #2;
      Hresetn = 1'b0;
      #1;
      check(mk("async_reset", 0, 0, 0, 0, 0, 0, 0, 'h99, 1, 0, 0, 0, 1, 0, 0, 0, 0));
      repeat (2) @(posedge Hclk);
      @(negedge Hclk);
      Hresetn = 1'b1;
      m_pwdata = '0;
      model_txn('b010, 0, 'h60, 'h0, 'hA5A5_0001, 1, 0);
      run_q();

      for (int t = 0; t < 120; t++) begin
         logic [31:0] sel;
         sel = ($urandom_range(0, 4) == 0) ? ($urandom & 32'd7) : (32'd1 << $urandom_range(0, 2));
         model_txn(sel, rb(), $urandom, $urandom, $urandom, $urandom_range(0, 5),
                   ($urandom_range(0, 4) == 0) ? 32'd1 : 32'd0);
         run_q();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
